bus_slave_port: RTL and testbench
=================================

// Module: bus_slave_port
// PURPOSE
//  Responder end of the serial address/data bus: one slave port with local byte memory.
//  Receives the 12-bit in-slave offset MSB-first after the bus decoder selects it.
//  Write: deserialises 8 data bits aligned to the last 8 offset bits and writes memory.
//  Read: fetches the byte, pulses slave_valid, then shifts the byte out MSB-first.
// PARAMETERS
//  ADDR_W       12    offset bits received (total 14-bit bus address minus 2 slave-ID bits)
//  DATA_W       8     data bits per transfer
//  MEM_DEPTH    4096  bytes of local memory (2**ADDR_W)
//  WAIT_CYCLES  4     extra read wait states, used only with SLAVE_WAIT_EN
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  sel          in   1       bus decoder has routed the current transaction to this slave
//  valid        in   1       transaction frame active (master valid_s)
//  write_en     in   1       1 = write, 0 = read (master write_en_slave)
//  addr_rx      in   1       serial offset bit, MSB first
//  data_rx      in   1       serial write-data bit, MSB first
//  data_tx      out  1       serial read-data bit, MSB first
//  slave_valid  out  1       one-cycle pulse: read data follows on data_tx
//  slave_ready  out  1       1 = idle, can accept a transaction
// BEHAVIOUR
//  Reset: state IDLE; data_tx=0, slave_valid=0, slave_ready=1; counters/shift regs 0.
//   Memory contents are NOT cleared by reset.
//  States: IDLE, RX, WR, RD_WAIT, RD_VALID, TX.
//  IDLE: slave_ready=1. sel&valid -> RX; write_en latched; bit counter cleared.
//  RX: each edge samples addr_rx into offset shift reg; cnt++. From cnt>=ADDR_W-DATA_W
//   (bit 5 of 12) data_rx is also shifted in when write_en latched = 1.
//   After ADDR_W samples: write -> WR, read -> RD_WAIT. slave_ready=0 in all non-IDLE.
//  WR: one cycle, memory[offset] <= data shift reg; -> IDLE.
//  RD_WAIT: issue RAM read (1-cycle sync latency); -> RD_VALID next cycle.
//  RD_VALID: slave_valid=1 for exactly one cycle, load tx shift reg; -> TX.
//  TX: data_tx = tx_reg[DATA_W-1] on the first TX cycle and shifts left every edge;
//   exactly DATA_W bits, then data_tx=0, -> IDLE.
//  Abort: valid or sel deasserted in RX -> IDLE, no memory write. Drop of valid in
//   RD_*/TX is ignored; read completes (master holds off new frames via slave_ready).
//  sel&valid while not IDLE: ignored, no error. Offset wraps modulo MEM_DEPTH.
//  Reset mid-transaction: return to IDLE next edge, any pending write is discarded.
// CONFIGURATION
//  SLAVE_WAIT_EN defined: RD_WAIT holds WAIT_CYCLES+1 cycles (counter) before
//   RD_VALID, emulating slow memory; slave_ready stays 0 throughout.
//  Undefined: RD_WAIT is exactly 1 cycle; WAIT_CYCLES unused.
// STRUCTURE
//  bus_pkg: state encodings, ADDR_W/DATA_W/slave-ID width (2) constants shared with master
//   and decoder.
//  Sub-module slave_bram: single-port synchronous RAM, DATA_W x MEM_DEPTH, 1-cycle read.
//  Top: FSM, bit counter (5 b), offset/data/tx shift registers.
// TESTING
//  Write 12'h0A5 <- 8'h3C, then read 12'h0A5 -> slave_valid pulse, data_tx 0,0,1,1,1,1,0,0.
//  Read after back-to-back writes 12'hFFF<-8'hFF and 12'h000<-8'h81: reads return FF, 81.
//  valid drops after 7 of 12 RX bits on write 12'h010<-8'hAA -> IDLE, mem[12'h010] unchanged.
//  Reset during TX bit 3 -> next edge slave_ready=1, data_tx=0; memory contents retained.
//  SLAVE_WAIT_EN, WAIT_CYCLES=4: last addr bit to slave_valid = 6 cycles (vs 2 without).
//  sel&valid held during TX of a read -> ignored; new frame accepted only after IDLE.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared serial-bus constants and slave FSM encoding for master, decoder and slave ports.
package bus_pkg;

   localparam int unsigned SLAVE_ID_W  = 2;
   localparam int unsigned ADDR_W      = 12;
   localparam int unsigned BUS_ADDR_W  = ADDR_W + SLAVE_ID_W;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned MEM_DEPTH   = 2 ** ADDR_W;
   localparam int unsigned WAIT_CYCLES = 4;
   localparam int unsigned CNT_W       = 5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RX       = 3'd1,
      ST_WR       = 3'd2,
      ST_RD_WAIT  = 3'd3,
      ST_RD_VALID = 3'd4,
      ST_TX       = 3'd5
   } slave_state_t;

   // Data bits ride on the last DATA_W offset bits of the frame.
   function automatic logic is_data_bit(input logic [CNT_W-1:0] cnt);
      return cnt >= CNT_W'(ADDR_W - DATA_W);
   endfunction

endpackage

// File: rtl/slave_bram.sv
// Single-port synchronous byte RAM with one-cycle read latency; contents survive reset.
module slave_bram
   import bus_pkg::*;
(
   input  logic              clock,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we) mem_q[addr] <= wdata;
      if (re) rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/bus_slave_port.sv
// Serial bus slave port: receives offset (and write data) MSB-first, writes or reads local RAM.
// Optional SLAVE_WAIT_EN stretches the read wait state by WAIT_CYCLES to model slow memory.
module bus_slave_port
   import bus_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic sel,
   input  logic valid,
   input  logic write_en,
   input  logic addr_rx,
   input  logic data_rx,
   output logic data_tx,
   output logic slave_valid,
   output logic slave_ready
);

   slave_state_t      state_q, state_d;
   logic              wr_q, wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] offset_q, offset_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              data_tx_q, data_tx_d;
   logic              slave_valid_q, slave_valid_d;
   logic              slave_ready_q, slave_ready_d;

   logic              ram_we;
   logic              ram_re;
   logic [DATA_W-1:0] ram_rdata;

   slave_bram u_bram (
      .clock (clock),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (offset_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // A reset arriving during WR must not commit the write.
   assign ram_we = (state_q == ST_WR) && !reset;
   assign ram_re = (state_q == ST_RD_WAIT);

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      cnt_d     = cnt_q;
      offset_d  = offset_q;
      wdata_d   = wdata_q;
      tx_d      = tx_q;
      data_tx_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sel && valid) begin
               state_d = ST_RX;
               wr_d    = write_en;
               cnt_d   = '0;
            end
         end
         ST_RX: begin
            if (!(sel && valid)) begin
               state_d = ST_IDLE;
            end else begin
               offset_d = {offset_q[ADDR_W-2:0], addr_rx};
               if (wr_q && is_data_bit(cnt_q)) wdata_d = {wdata_q[DATA_W-2:0], data_rx};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                  state_d = wr_q ? ST_WR : ST_RD_WAIT;
                  cnt_d   = '0;
               end
            end
         end
         ST_WR: begin
            state_d = ST_IDLE;
         end
         ST_RD_WAIT: begin
`ifdef SLAVE_WAIT_EN
            if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
               state_d = ST_RD_VALID;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`else
            state_d = ST_RD_VALID;
`endif
         end
         ST_RD_VALID: begin
            // MSB goes straight to the output flop; the rest waits in tx_q.
            data_tx_d = ram_rdata[DATA_W-1];
            tx_d      = {ram_rdata[DATA_W-2:0], 1'b0};
            cnt_d     = '0;
            state_d   = ST_TX;
         end
         ST_TX: begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               data_tx_d = tx_q[DATA_W-1];
               tx_d      = {tx_q[DATA_W-2:0], 1'b0};
               cnt_d     = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      slave_valid_d = (state_d == ST_RD_VALID);
      slave_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         wr_q          <= 1'b0;
         cnt_q         <= '0;
         offset_q      <= '0;
         wdata_q       <= '0;
         tx_q          <= '0;
         data_tx_q     <= 1'b0;
         slave_valid_q <= 1'b0;
         slave_ready_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         wr_q          <= wr_d;
         cnt_q         <= cnt_d;
         offset_q      <= offset_d;
         wdata_q       <= wdata_d;
         tx_q          <= tx_d;
         data_tx_q     <= data_tx_d;
         slave_valid_q <= slave_valid_d;
         slave_ready_q <= slave_ready_d;
      end
   end

   assign data_tx     = data_tx_q;
   assign slave_valid = slave_valid_q;
   assign slave_ready = slave_ready_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Scoreboard bench for bus_slave_port: shadow memory predicts read bytes, queue pairs them with TX.
module tb_bus_slave_port;

   logic clock    = 1'b0;
   logic reset    = 1'b1;
   logic sel      = 1'b0;
   logic valid    = 1'b0;
   logic write_en = 1'b0;
   logic addr_rx  = 1'b0;
   logic data_rx  = 1'b0;
   logic data_tx;
   logic slave_valid;
   logic slave_ready;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q [$];
   logic [7:0] model [logic [11:0]];

`ifdef SLAVE_WAIT_EN
   localparam int EXP_LAT = 6;
`else
   localparam int EXP_LAT = 2;
`endif

   bus_slave_port dut (
      .clock       (clock),
      .reset       (reset),
      .sel         (sel),
      .valid       (valid),
      .write_en    (write_en),
      .addr_rx     (addr_rx),
      .data_rx     (data_rx),
      .data_tx     (data_tx),
      .slave_valid (slave_valid),
      .slave_ready (slave_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drives one frame; returns at the negedge after the last bit (or after the abort edge).
   task automatic send_frame(input bit wr, input logic [11:0] off, input logic [7:0] d,
                             input int abort_at);
      @(negedge clock);
      sel = 1'b1; valid = 1'b1; write_en = wr;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (i == abort_at) begin
            valid = 1'b0;
            sel   = 1'b0;
            break;
         end
         addr_rx = off[4'(11 - i)];
         data_rx = (i >= 4) ? d[3'(11 - i)] : 1'b0;
      end
      @(negedge clock);
      sel = 1'b0; valid = 1'b0; write_en = 1'b0; addr_rx = 1'b0; data_rx = 1'b0;
      if (wr && abort_at < 0) model[off] = d;
   endtask

   task automatic do_read(input logic [11:0] off, input bit busy_hold, input int reset_at);
      logic [7:0] got;
      int lat;
      exp_q.push_back(model[off]);
      send_frame(1'b0, off, 8'h00, -1);
      chk("ready_busy", 32'(slave_ready), 32'd0);
      if (busy_hold) begin
         sel = 1'b1; valid = 1'b1; write_en = 1'b1; addr_rx = 1'b1; data_rx = 1'b1;
      end
      lat = 1;
      while (!slave_valid && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      chk("rd_latency", 32'(lat), 32'(EXP_LAT));
      got = '0;
      for (int b = 0; b < 8; b++) begin
         @(negedge clock);
         if (b == 0) chk("valid_pulse", 32'(slave_valid), 32'd0);
         if (busy_hold) chk("ready_tx", 32'(slave_ready), 32'd0);
         if (b == reset_at) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            chk("rst_ready", 32'(slave_ready), 32'd1);
            chk("rst_tx", 32'(data_tx), 32'd0);
            chk("rst_valid", 32'(slave_valid), 32'd0);
            void'(exp_q.pop_front());
            return;
         end
         got = {got[6:0], data_tx};
      end
      sel = 1'b0; valid = 1'b0; write_en = 1'b0; addr_rx = 1'b0; data_rx = 1'b0;
      chk("rd_data", 32'(got), 32'(exp_q.pop_front()));
      @(negedge clock);
      chk("idle_ready", 32'(slave_ready), 32'd1);
      chk("idle_tx", 32'(data_tx), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      chk("reset_ready", 32'(slave_ready), 32'd1);
      chk("reset_valid", 32'(slave_valid), 32'd0);
      chk("reset_tx", 32'(data_tx), 32'd0);
      reset = 1'b0;

      send_frame(1'b1, 12'h0A5, 8'h3C, -1);
      do_read(12'h0A5, 1'b0, -1);

      send_frame(1'b1, 12'hFFF, 8'hFF, -1);
      send_frame(1'b1, 12'h000, 8'h81, -1);
      do_read(12'hFFF, 1'b0, -1);
      do_read(12'h000, 1'b0, -1);

      send_frame(1'b1, 12'h010, 8'h55, -1);
      send_frame(1'b1, 12'h010, 8'hAA, 7);
      chk("abort_ready", 32'(slave_ready), 32'd1);
      do_read(12'h010, 1'b0, -1);

      do_read(12'h0A5, 1'b0, 3);
      do_read(12'h0A5, 1'b0, -1);

      do_read(12'hFFF, 1'b1, -1);
      do_read(12'hFFF, 1'b0, -1);

      for (int k = 0; k < 4; k++) begin
         logic [11:0] a;
         logic [7:0]  d;
         a = 12'($urandom_range(32'h100, 32'hF00));
         d = 8'($urandom);
         send_frame(1'b1, a, d, -1);
         do_read(a, 1'b0, -1);
      end

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
